// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
package seg7_pkg;

    localparam int DEFAULT_DIGIT_PERIOD = 10000;
    localparam int DEFAULT_BLANK_CYCLES = 100;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Active-low segments {g,f,e,d,c,b,a}; entry n sits at SEG_TABLE[n].
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [7:0] SEL_OFF = 8'hFF;
    localparam logic [6:0] LED_OFF = 7'h7F;

endpackage

// File: rtl/seg7_decoder.sv
// Hex nibble to active-low 7-segment pattern.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit time-multiplexed 7-segment driver with per-frame input snapshot
// and a dark interval at the start of every digit slot to suppress ghosting.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGIT_PERIOD = DEFAULT_DIGIT_PERIOD,
    parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
    input  logic        clk_i,
    input  logic        rst,
    input  logic [31:0] hex_data_i,
    input  logic [7:0]  bitmask_i,
    output logic [6:0]  hex_led_o,
    output logic [7:0]  hex_sel_o,
    output logic        frame_start_o
);

    localparam int CNT_W = $clog2(DIGIT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIGIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       idx_reg;
    scan_state_t      state_reg;
    logic [31:0]      snap_data_reg;
    logic [7:0]       snap_mask_reg;
    logic [7:0]       hex_sel_reg;
    logic [6:0]       hex_led_reg;

    logic             cnt_wrap;
    logic             snap_take;
    logic [3:0]       digit_nibble [8];
    logic [3:0]       sel_nibble;
    logic [6:0]       sel_seg;

    for (genvar gi = 0; gi < 8; gi++) begin : g_nibble
        assign digit_nibble[gi] = snap_data_reg[4*gi +: 4];
    end

    assign sel_nibble = digit_nibble[idx_reg];

    seg7_decoder u_decoder (
        .nibble (sel_nibble),
        .seg    (sel_seg)
    );

    assign cnt_wrap  = (cnt_reg == CNT_MAX);
    assign snap_take = (idx_reg == 3'd0) && (cnt_reg == '0);

    always_ff @(posedge clk_i) begin
        if (rst) begin
            cnt_reg       <= '0;
            idx_reg       <= 3'd0;
            state_reg     <= BLANK;
            snap_data_reg <= 32'h0;
            snap_mask_reg <= 8'h00;
            hex_sel_reg   <= SEL_OFF;
            hex_led_reg   <= LED_OFF;
        end else begin
            if (snap_take) begin
                snap_data_reg <= hex_data_i;
                snap_mask_reg <= bitmask_i;
            end

            if (cnt_wrap) begin
                cnt_reg <= '0;
                idx_reg <= idx_reg + 3'd1;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end

            // A slot whose blank interval ends on its last cycle never lights.
            case (state_reg)
                BLANK: if (cnt_reg == BLANK_END && !cnt_wrap) state_reg <= SHOW;
                SHOW:  if (cnt_wrap) state_reg <= BLANK;
                default: state_reg <= BLANK;
            endcase

            if (state_reg == SHOW && snap_mask_reg[idx_reg]) begin
                hex_sel_reg <= ~(8'b1 << idx_reg);
                hex_led_reg <= sel_seg;
            end else begin
                hex_sel_reg <= SEL_OFF;
                hex_led_reg <= LED_OFF;
            end
        end
    end

    assign hex_sel_o     = hex_sel_reg;
    assign hex_led_o     = hex_led_reg;
    // Flags the snapshot cycle itself, so it cannot wait for a register stage.
    assign frame_start_o = !rst && snap_take;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle-indexed reference model queues
// the expected outputs of every cycle and a monitor compares them on negedge.
module tb_seg7_scan_driver;

    localparam int DP    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 8 * DP;

    logic        clk_i = 1'b0;
    logic        rst   = 1'b1;
    logic [31:0] hex_data_i = 32'h0;
    logic [7:0]  bitmask_i  = 8'h00;
    logic [6:0]  hex_led_o;
    logic [7:0]  hex_sel_o;
    logic        frame_start_o;

    seg7_scan_driver #(
        .DIGIT_PERIOD (DP),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk_i         (clk_i),
        .rst           (rst),
        .hex_data_i    (hex_data_i),
        .bitmask_i     (bitmask_i),
        .hex_led_o     (hex_led_o),
        .hex_sel_o     (hex_sel_o),
        .frame_start_o (frame_start_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] sel;
        logic [6:0] led;
        logic       fs;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: t counts cycles since the last reset release.
    int          t_model  = 0;
    logic [31:0] mdl_data = 32'h0;
    logic [7:0]  mdl_mask = 8'h00;
    logic [7:0]  pend_sel = 8'hFF;
    logic [6:0]  pend_led = 7'h7F;
    int          cyc_no   = 0;

    task automatic step(input logic r, input logic [31:0] d, input logic [7:0] m);
        exp_t e;
        int   c;
        int   i;
        logic [31:0] sh;
        rst        = r;
        hex_data_i = d;
        bitmask_i  = m;
        e.sel = pend_sel;
        e.led = pend_led;
        e.fs  = !r && (t_model % FRAME == 0);
        exp_q.push_back(e);
        if (r) begin
            pend_sel = 8'hFF;
            pend_led = 7'h7F;
            t_model  = 0;
        end else begin
            if (t_model % FRAME == 0) begin
                mdl_data = d;
                mdl_mask = m;
            end
            c = t_model % DP;
            i = (t_model / DP) % 8;
            if (c > BC && mdl_mask[i]) begin
                sh       = mdl_data >> (4 * i);
                pend_sel = ~(8'd1 << i);
                pend_led = seg_ref[sh[3:0]];
            end else begin
                pend_sel = 8'hFF;
                pend_led = 7'h7F;
            end
            t_model++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic run(input int n, input logic [31:0] d, input logic [7:0] m);
        repeat (n) step(1'b0, d, m);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc_no++;
                n_cmp++;
                if (hex_sel_o !== e.sel) begin
                    n_err++;
                    $display("FAIL sel cycle %0d: got %02h expected %02h", cyc_no, hex_sel_o, e.sel);
                end
                n_cmp++;
                if (hex_led_o !== e.led) begin
                    n_err++;
                    $display("FAIL led cycle %0d: got %02h expected %02h", cyc_no, hex_led_o, e.led);
                end
                n_cmp++;
                if (frame_start_o !== e.fs) begin
                    n_err++;
                    $display("FAIL frame_start cycle %0d: got %0b expected %0b", cyc_no, frame_start_o, e.fs);
                end
                n_cmp++;
                if ($countones(~hex_sel_o) > 1) begin
                    n_err++;
                    $display("FAIL onehot cycle %0d: got %02h expected at most one low bit", cyc_no, hex_sel_o);
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] d;
        logic [7:0]  m;
        logic [31:0] r32;
        logic        r;
        repeat (2) @(posedge clk_i);
        #1;

        // Reset held for three cycles, then a full scan of 0..7.
        repeat (3) step(1'b1, 32'h76543210, 8'hFF);
        run(2 * FRAME, 32'h76543210, 8'hFF);

        // Sparse mask: only digits 0 and 2.
        run(2 * FRAME, 32'h76543210, 8'h05);

        // Digit 3 changes during slot 1; old value holds for the rest of the frame.
        while (t_model % FRAME != 0) step(1'b0, 32'h76543210, 8'hFF);
        run(DP + 3, 32'h76543210, 8'hFF);
        run(2 * FRAME, 32'h7654A210, 8'hFF);

        // Single-cycle reset during the lit part of slot 5.
        while (t_model % FRAME != 5 * DP + 4) step(1'b0, 32'h7654A210, 8'hFF);
        step(1'b1, 32'h7654A210, 8'hFF);
        run(2 * FRAME, 32'h89ABCDEF, 8'hFF);

        // Digit 0 swept through every hex value, other digits random.
        while (t_model % FRAME != 0) step(1'b0, 32'h89ABCDEF, 8'hFF);
        for (int v = 0; v < 16; v++) begin
            r32 = $urandom;
            d   = {r32[31:4], 4'(v)};
            m   = 8'($urandom_range(0, 255)) | 8'h01;
            run(FRAME, d, m);
        end

        // Random data, masks and occasional resets.
        d = $urandom;
        m = 8'($urandom_range(0, 255));
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 15) == 0) d = $urandom;
            if ($urandom_range(0, 31) == 0) m = 8'($urandom_range(0, 255));
            r = ($urandom_range(0, 199) == 0);
            step(r, d, m);
        end

        @(negedge clk_i);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
